// File: rtl/adam_periph_uart_rx_ovs_if.sv
// Stream and pause handshake bundles for the oversampling UART receiver.
// Stream carries zero-extended characters; pause is a request/acknowledge pair.
interface adam_periph_uart_rx_ovs_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

interface adam_periph_uart_rx_ovs_pause_if;
    logic req;
    logic ack;

    modport master (output req, input ack);
    modport slave  (input req, output ack);
endinterface

// File: rtl/adam_periph_uart_rx_ovs.sv
// UART receiver: majority-of-3 bit sampling, parity/frame/break/overrun detection, receive FIFO.
// Latency: push one cycle after last stop sample, mst.valid one cycle later; mst.ready stalls FIFO, overrun drops new chars.
module adam_periph_uart_rx_ovs #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          seq_clk,
    input  logic                          seq_rst,
    adam_periph_uart_rx_ovs_pause_if.slave pause,
    input  logic                          parity_select,
    input  logic                          parity_control,
    input  logic [3:0]                    data_length,
    input  logic [1:0]                    stop_bits,
    input  logic [DATA_WIDTH-1:0]         baud_rate,
    adam_periph_uart_rx_ovs_if.master     mst,
    input  logic                          rx,
    output logic                          err_parity,
    output logic                          err_frame,
    output logic                          err_overrun,
    output logic                          err_break,
    input  logic                          err_clear,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_e;
    state_e state_q, state_d;

    logic sync1_q, sync1_d, sync2_q, sync2_d;
    logic hist1_q, hist1_d, hist2_q, hist2_d;
    logic rx_s, maj, eval, start_ok, last_data, last_stop, brk_cond, par_exp;

    logic [DATA_WIDTH-1:0] cnt_q, cnt_d, baud_q, baud_d;
    logic [3:0]            len_q, len_d, idx_q, idx_d;
    logic [1:0]            stops_q, stops_d;
    logic                  par_en_q, par_en_d, par_sel_q, par_sel_d;
    logic [8:0]            shr_q, shr_d, push_dat_q, push_dat_d;
    logic                  stop_zero_q, stop_zero_d, stop_one_q, stop_one_d;
    logic                  push_q, push_d;
    logic                  set_par, set_frm, set_brk, set_ovr;
    logic                  err_par_q, err_par_d, err_frm_q, err_frm_d;
    logic                  err_ovr_q, err_ovr_d, err_brk_q, err_brk_d;
    logic                  ack_q, ack_d;

    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   lvl_q, lvl_d;
    logic          full, pop, wr_en, out_vld;

    // hist1/hist2 hold the two previous synchronized samples, so at a bit's
    // mid+1 cycle the vote covers mid-1, mid and mid+1.
    assign rx_s      = sync2_q;
    assign maj       = (hist2_q & hist1_q) | (hist2_q & rx_s) | (hist1_q & rx_s);
    assign eval      = (cnt_q == '0);
    assign start_ok  = (state_q == IDLE) && hist1_q && !rx_s
                       && (baud_rate >= DATA_WIDTH'(4)) && !ack_q;
    assign last_data = (idx_q == len_q - 4'd1);
    assign last_stop = (stops_q == 2'd0);
    assign brk_cond  = (shr_q == 9'd0) && !stop_one_q && !maj;
    assign par_exp   = (^shr_q) ^ par_sel_q;

    always_comb begin
        sync1_d = rx;
        sync2_d = sync1_q;
        hist1_d = sync2_q;
        hist2_d = hist1_q;
    end

    always_ff @(posedge seq_clk) begin
        if (seq_rst) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_ok) state_d = START;
            START:   if (eval) state_d = maj ? IDLE : DATA;
            DATA:    if (eval && last_data) state_d = par_en_q ? PARITY : STOP;
            PARITY:  if (eval) state_d = STOP;
            STOP:    if (eval && last_stop) state_d = brk_cond ? BREAK : IDLE;
            BREAK:   if (rx_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        baud_d      = baud_q;
        len_d       = len_q;
        idx_d       = idx_q;
        stops_d     = stops_q;
        par_en_d    = par_en_q;
        par_sel_d   = par_sel_q;
        shr_d       = shr_q;
        push_dat_d  = push_dat_q;
        stop_zero_d = stop_zero_q;
        stop_one_d  = stop_one_q;
        push_d      = 1'b0;
        set_par     = 1'b0;
        set_frm     = 1'b0;
        set_brk     = 1'b0;
        if (state_q inside {START, DATA, PARITY, STOP})
            cnt_d = eval ? baud_q - DATA_WIDTH'(1) : cnt_q - DATA_WIDTH'(1);
        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    // Frame format is frozen here; the first vote lands half a bit later.
                    cnt_d       = baud_rate >> 1;
                    baud_d      = baud_rate;
                    len_d       = (data_length < 4'd5) ? 4'd5 :
                                  (data_length > 4'd9) ? 4'd9 : data_length;
                    stops_d     = stop_bits;
                    par_en_d    = parity_control;
                    par_sel_d   = parity_select;
                    shr_d       = '0;
                    idx_d       = '0;
                    stop_zero_d = 1'b0;
                    stop_one_d  = 1'b0;
                end
            end
            DATA: begin
                if (eval) begin
                    for (int i = 0; i < 9; i++)
                        if (idx_q == i[3:0]) shr_d[i] = maj;
                    idx_d = idx_q + 4'd1;
                end
            end
            PARITY: begin
                if (eval && (maj != par_exp)) set_par = 1'b1;
            end
            STOP: begin
                if (eval) begin
                    if (maj) stop_one_d  = 1'b1;
                    else     stop_zero_d = 1'b1;
                    if (!last_stop) begin
                        stops_d = stops_q - 2'd1;
                    end else if (!stop_zero_q && maj) begin
                        push_d     = 1'b1;
                        push_dat_d = shr_q;
                    end else if (brk_cond) begin
                        set_brk = 1'b1;
                    end else begin
                        set_frm = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // A start edge seen in the same cycle as the request wins; ack waits for that frame.
    assign ack_d = pause.req && (ack_q || ((state_q == IDLE) && !start_ok));

    always_comb begin
        full    = (lvl_q == (AW+1)'(FIFO_DEPTH));
        out_vld = (lvl_q != '0) && !ack_q;
        pop     = out_vld && mst.ready;
        wr_en   = push_q && (!full || pop);
        set_ovr = push_q && full && !pop;
        wr_d    = wr_en ? wr_q + AW'(1) : wr_q;
        rd_d    = pop ? rd_q + AW'(1) : rd_q;
        lvl_d   = lvl_q + (AW+1)'(wr_en) - (AW+1)'(pop);
    end

    always_comb begin
        err_par_d = (err_par_q & ~err_clear) | set_par;
        err_frm_d = (err_frm_q & ~err_clear) | set_frm;
        err_ovr_d = (err_ovr_q & ~err_clear) | set_ovr;
        err_brk_d = (err_brk_q & ~err_clear) | set_brk;
    end

    always_ff @(posedge seq_clk) begin
        if (seq_rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            hist1_q     <= 1'b1;
            hist2_q     <= 1'b1;
            cnt_q       <= '0;
            baud_q      <= '0;
            len_q       <= 4'd8;
            idx_q       <= '0;
            stops_q     <= '0;
            par_en_q    <= 1'b0;
            par_sel_q   <= 1'b0;
            shr_q       <= '0;
            push_dat_q  <= '0;
            stop_zero_q <= 1'b0;
            stop_one_q  <= 1'b0;
            push_q      <= 1'b0;
            err_par_q   <= 1'b0;
            err_frm_q   <= 1'b0;
            err_ovr_q   <= 1'b0;
            err_brk_q   <= 1'b0;
            ack_q       <= 1'b0;
            wr_q        <= '0;
            rd_q        <= '0;
            lvl_q       <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            hist1_q     <= hist1_d;
            hist2_q     <= hist2_d;
            cnt_q       <= cnt_d;
            baud_q      <= baud_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            stops_q     <= stops_d;
            par_en_q    <= par_en_d;
            par_sel_q   <= par_sel_d;
            shr_q       <= shr_d;
            push_dat_q  <= push_dat_d;
            stop_zero_q <= stop_zero_d;
            stop_one_q  <= stop_one_d;
            push_q      <= push_d;
            err_par_q   <= err_par_d;
            err_frm_q   <= err_frm_d;
            err_ovr_q   <= err_ovr_d;
            err_brk_q   <= err_brk_d;
            ack_q       <= ack_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            lvl_q       <= lvl_d;
        end
    end

    always_ff @(posedge seq_clk) begin
        if (wr_en) mem_q[wr_q] <= push_dat_q;
    end

    assign mst.valid   = out_vld && !seq_rst;
    assign mst.data    = (out_vld && !seq_rst) ? {{(DATA_WIDTH-9){1'b0}}, mem_q[rd_q]} : '0;
    assign pause.ack   = ack_q && !seq_rst;
    assign fifo_level  = seq_rst ? '0 : lvl_q;
    assign err_parity  = err_par_q;
    assign err_frame   = err_frm_q;
    assign err_overrun = err_ovr_q;
    assign err_break   = err_brk_q;
endmodule

// File: tb/tb_adam_periph_uart_rx_ovs.sv
// Directed bench for the oversampling UART receiver: one task per scenario, inline checks.
module tb_adam_periph_uart_rx_ovs;
    localparam int DW = 32;
    localparam int FD = 8;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic                 rst;
    logic                 parity_select, parity_control, rx, err_clear;
    logic [3:0]           data_length;
    logic [1:0]           stop_bits;
    logic [DW-1:0]        baud_rate;
    logic                 err_parity, err_frame, err_overrun, err_break;
    logic [$clog2(FD):0]  fifo_level;

    adam_periph_uart_rx_ovs_if #(.DATA_WIDTH(DW)) mst ();
    adam_periph_uart_rx_ovs_pause_if pause ();

    int n_cmp = 0;
    int n_bad = 0;
    int cur_baud = 16;
    logic [DW-1:0] beats[$];

    adam_periph_uart_rx_ovs #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
        .seq_clk        (clk),
        .seq_rst        (rst),
        .pause          (pause),
        .parity_select  (parity_select),
        .parity_control (parity_control),
        .data_length    (data_length),
        .stop_bits      (stop_bits),
        .baud_rate      (baud_rate),
        .mst            (mst),
        .rx             (rx),
        .err_parity     (err_parity),
        .err_frame      (err_frame),
        .err_overrun    (err_overrun),
        .err_break      (err_break),
        .err_clear      (err_clear),
        .fifo_level     (fifo_level)
    );

    // A beat is committed at the next rising edge when valid and ready are both high mid-cycle.
    always @(negedge clk)
        if (rst === 1'b0 && mst.valid === 1'b1 && mst.ready === 1'b1)
            beats.push_back(mst.data);

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int b, input logic [3:0] len, input logic pen,
                           input logic psel, input logic [1:0] sb);
        cur_baud       = b;
        baud_rate      = DW'(b);
        data_length    = len;
        parity_control = pen;
        parity_select  = psel;
        stop_bits      = sb;
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
    endtask

    task automatic send_frame(input logic [8:0] d, input int nb, input logic pen,
                              input logic pbit, input int ns, input logic sval,
                              input logic spike);
        rx = 1'b0;
        tick(cur_baud);
        for (int i = 0; i < nb; i++) begin
            if (spike) begin
                rx = d[i];
                tick(cur_baud / 2 - 1);
                rx = ~d[i];
                tick(1);
                rx = d[i];
                tick(cur_baud - cur_baud / 2);
            end else begin
                rx = d[i];
                tick(cur_baud);
            end
        end
        if (pen) begin
            rx = pbit;
            tick(cur_baud);
        end
        for (int i = 0; i < ns; i++) begin
            rx = sval;
            tick(cur_baud);
        end
        rx = 1'b1;
    endtask

    task automatic wait_beats(input int n, input int budget);
        for (int k = 0; k < budget && beats.size() < n; k++) tick(1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        n_cmp++;
        if (mst.valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_valid: got %b want 0", mst.valid);
        end
        n_cmp++;
        if (pause.ack !== 1'b0) begin
            n_bad++; $display("FAIL reset_ack: got %b want 0", pause.ack);
        end
        n_cmp++;
        if (fifo_level !== '0) begin
            n_bad++; $display("FAIL reset_level: got %0d want 0", fifo_level);
        end
        n_cmp++;
        if (mst.data !== '0) begin
            n_bad++; $display("FAIL reset_data: got %h want 0", mst.data);
        end
        n_cmp++;
        if ({err_parity, err_frame, err_overrun, err_break} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_flags: got %b want 0000",
                              {err_parity, err_frame, err_overrun, err_break});
        end
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_baud434();
        logic [DW-1:0] got;
        beats.delete();
        set_cfg(434, 4'd8, 1'b0, 1'b0, 2'd0);
        send_frame(9'h055, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
        send_frame(9'h0A3, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
        wait_beats(2, 2000);
        n_cmp++;
        if (beats.size() != 2) begin
            n_bad++; $display("FAIL b434_count: got %0d want 2", beats.size());
        end
        got = (beats.size() > 0) ? beats.pop_front() : 'x;
        n_cmp++;
        if (got !== 32'h55) begin
            n_bad++; $display("FAIL b434_first: got %h want 55", got);
        end
        got = (beats.size() > 0) ? beats.pop_front() : 'x;
        n_cmp++;
        if (got !== 32'hA3) begin
            n_bad++; $display("FAIL b434_second: got %h want a3", got);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] got;
        beats.delete();
        set_cfg(8, 4'd8, 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 256; i++)
            send_frame(9'(i), 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
        wait_beats(256, 200);
        n_cmp++;
        if (beats.size() != 256) begin
            n_bad++; $display("FAIL b2b_count: got %0d want 256", beats.size());
        end
        for (int i = 0; i < 256; i++) begin
            got = (beats.size() > 0) ? beats.pop_front() : 'x;
            n_cmp++;
            if (got !== DW'(i)) begin
                n_bad++; $display("FAIL b2b_data[%0d]: got %h want %h", i, got, DW'(i));
            end
        end
        n_cmp++;
        if ({err_parity, err_frame, err_overrun, err_break} !== 4'b0000) begin
            n_bad++; $display("FAIL b2b_flags: got %b want 0000",
                              {err_parity, err_frame, err_overrun, err_break});
        end
    endtask

    task automatic test_formats();
        logic [DW-1:0] got;
        beats.delete();
        set_cfg(16, 4'd5, 1'b0, 1'b0, 2'd0);
        send_frame(9'h015, 5, 1'b0, 1'b0, 1, 1'b1, 1'b0);
        data_length = 4'd3;
        send_frame(9'h00B, 5, 1'b0, 1'b0, 1, 1'b1, 1'b0);
        data_length = 4'd9;
        stop_bits   = 2'd1;
        send_frame(9'h1C3, 9, 1'b0, 1'b0, 2, 1'b1, 1'b0);
        data_length = 4'd15;
        stop_bits   = 2'd0;
        send_frame(9'h0A5, 9, 1'b0, 1'b0, 1, 1'b1, 1'b0);
        data_length = 4'd8;
        fork
            send_frame(9'h096, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
            begin
                tick(48);
                data_length = 4'd5;
                baud_rate   = DW'(9);
            end
        join
        set_cfg(16, 4'd8, 1'b0, 1'b0, 2'd0);
        wait_beats(5, 200);
        n_cmp++;
        if (beats.size() != 5) begin
            n_bad++; $display("FAIL fmt_count: got %0d want 5", beats.size());
        end
        got = (beats.size() > 0) ? beats.pop_front() : 'x;
        n_cmp++;
        if (got !== 32'h15) begin n_bad++; $display("FAIL fmt_len5: got %h want 15", got); end
        got = (beats.size() > 0) ? beats.pop_front() : 'x;
        n_cmp++;
        if (got !== 32'h0B) begin n_bad++; $display("FAIL fmt_clamp_lo: got %h want 0b", got); end
        got = (beats.size() > 0) ? beats.pop_front() : 'x;
        n_cmp++;
        if (got !== 32'h1C3) begin n_bad++; $display("FAIL fmt_len9_2stop: got %h want 1c3", got); end
        got = (beats.size() > 0) ? beats.pop_front() : 'x;
        n_cmp++;
        if (got !== 32'hA5) begin n_bad++; $display("FAIL fmt_clamp_hi: got %h want a5", got); end
        got = (beats.size() > 0) ? beats.pop_front() : 'x;
        n_cmp++;
        if (got !== 32'h96) begin n_bad++; $display("FAIL fmt_latched_cfg: got %h want 96", got); end
    endtask

    task automatic test_parity();
        logic [DW-1:0] got;
        beats.delete();
        pulse_clear();
        set_cfg(16, 4'd8, 1'b1, 1'b1, 2'd0);
        send_frame(9'h05A, 8, 1'b1, 1'b1, 1, 1'b1, 1'b0);
        wait_beats(1, 200);
        got = (beats.size() > 0) ? beats.pop_front() : 'x;
        n_cmp++;
        if (got !== 32'h5A) begin n_bad++; $display("FAIL par_good_data: got %h want 5a", got); end
        n_cmp++;
        if (err_parity !== 1'b0) begin n_bad++; $display("FAIL par_good_flag: got %b want 0", err_parity); end
        send_frame(9'h05A, 8, 1'b1, 1'b0, 1, 1'b1, 1'b0);
        wait_beats(1, 200);
        got = (beats.size() > 0) ? beats.pop_front() : 'x;
        n_cmp++;
        if (got !== 32'h5A) begin n_bad++; $display("FAIL par_bad_data: got %h want 5a", got); end
        n_cmp++;
        if (err_parity !== 1'b1) begin n_bad++; $display("FAIL par_bad_flag: got %b want 1", err_parity); end
        pulse_clear();
        n_cmp++;
        if (err_parity !== 1'b0) begin n_bad++; $display("FAIL par_clear: got %b want 0", err_parity); end
        set_cfg(16, 4'd8, 1'b0, 1'b0, 2'd0);
    endtask

    task automatic test_frame_break();
        logic [DW-1:0] got;
        beats.delete();
        pulse_clear();
        set_cfg(16, 4'd8, 1'b0, 1'b0, 2'd0);
        send_frame(9'h033, 8, 1'b0, 1'b0, 1, 1'b0, 1'b0);
        tick(3 * 16);
        n_cmp++;
        if (beats.size() != 0) begin n_bad++; $display("FAIL frm_nobeat: got %0d want 0", beats.size()); end
        n_cmp++;
        if ({err_frame, err_break} !== 2'b10) begin
            n_bad++; $display("FAIL frm_flags: got frame/break %b want 10", {err_frame, err_break});
        end
        pulse_clear();
        rx = 1'b0;
        tick(20 * 16);
        n_cmp++;
        if ({err_frame, err_break} !== 2'b01) begin
            n_bad++; $display("FAIL brk_flags: got frame/break %b want 01", {err_frame, err_break});
        end
        rx = 1'b1;
        tick(2 * 16);
        send_frame(9'h011, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
        wait_beats(1, 200);
        n_cmp++;
        if (beats.size() != 1) begin n_bad++; $display("FAIL brk_after_count: got %0d want 1", beats.size()); end
        got = (beats.size() > 0) ? beats.pop_front() : 'x;
        n_cmp++;
        if (got !== 32'h11) begin n_bad++; $display("FAIL brk_after_data: got %h want 11", got); end
        pulse_clear();
    endtask

    task automatic test_glitch();
        logic [DW-1:0] got;
        beats.delete();
        pulse_clear();
        set_cfg(16, 4'd8, 1'b0, 1'b0, 2'd0);
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(3 * 16);
        n_cmp++;
        if (beats.size() != 0) begin n_bad++; $display("FAIL glitch_nobeat: got %0d want 0", beats.size()); end
        n_cmp++;
        if ({err_parity, err_frame, err_overrun, err_break} !== 4'b0000) begin
            n_bad++; $display("FAIL glitch_flags: got %b want 0000",
                              {err_parity, err_frame, err_overrun, err_break});
        end
        send_frame(9'h05A, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
        send_frame(9'h0C3, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
        wait_beats(2, 200);
        got = (beats.size() > 0) ? beats.pop_front() : 'x;
        n_cmp++;
        if (got !== 32'h5A) begin n_bad++; $display("FAIL spike_a: got %h want 5a", got); end
        got = (beats.size() > 0) ? beats.pop_front() : 'x;
        n_cmp++;
        if (got !== 32'hC3) begin n_bad++; $display("FAIL spike_b: got %h want c3", got); end
    endtask

    task automatic test_overrun();
        logic [DW-1:0] got;
        beats.delete();
        pulse_clear();
        set_cfg(16, 4'd8, 1'b0, 1'b0, 2'd0);
        mst.ready = 1'b0;
        for (int i = 0; i < 10; i++)
            send_frame(9'(8'h10 + i), 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
        tick(16);
        n_cmp++;
        if (fifo_level !== 4'd8) begin n_bad++; $display("FAIL ovr_level: got %0d want 8", fifo_level); end
        n_cmp++;
        if (err_overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_flag: got %b want 1", err_overrun); end
        n_cmp++;
        if (mst.valid !== 1'b1 || mst.data !== 32'h10) begin
            n_bad++; $display("FAIL ovr_head_hold: got valid %b data %h want 1 10", mst.valid, mst.data);
        end
        mst.ready = 1'b1;
        tick(20);
        n_cmp++;
        if (beats.size() != 8) begin n_bad++; $display("FAIL ovr_count: got %0d want 8", beats.size()); end
        for (int i = 0; i < 8; i++) begin
            got = (beats.size() > 0) ? beats.pop_front() : 'x;
            n_cmp++;
            if (got !== DW'(8'h10 + i)) begin
                n_bad++; $display("FAIL ovr_data[%0d]: got %h want %h", i, got, DW'(8'h10 + i));
            end
        end
        pulse_clear();
    endtask

    task automatic test_pause();
        logic [DW-1:0] got;
        beats.delete();
        set_cfg(16, 4'd8, 1'b0, 1'b0, 2'd0);
        mst.ready = 1'b1;
        fork
            send_frame(9'h03C, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
            begin
                tick(5 * 16);
                pause.req = 1'b1;
            end
        join
        n_cmp++;
        if (pause.ack !== 1'b1) begin n_bad++; $display("FAIL pause_ack: got %b want 1", pause.ack); end
        n_cmp++;
        if (fifo_level !== 4'd1 || mst.valid !== 1'b0) begin
            n_bad++; $display("FAIL pause_hold: got level %0d valid %b want 1 0", fifo_level, mst.valid);
        end
        send_frame(9'h077, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
        tick(2 * 16);
        n_cmp++;
        if (fifo_level !== 4'd1 || beats.size() != 0) begin
            n_bad++; $display("FAIL pause_ignore_rx: got level %0d beats %0d want 1 0", fifo_level, beats.size());
        end
        pause.req = 1'b0;
        tick(1);
        n_cmp++;
        if (pause.ack !== 1'b0) begin n_bad++; $display("FAIL pause_release: got %b want 0", pause.ack); end
        tick(20);
        n_cmp++;
        if (beats.size() != 1) begin n_bad++; $display("FAIL pause_count: got %0d want 1", beats.size()); end
        got = (beats.size() > 0) ? beats.pop_front() : 'x;
        n_cmp++;
        if (got !== 32'h3C) begin n_bad++; $display("FAIL pause_data: got %h want 3c", got); end
    endtask

    task automatic test_reset_midframe();
        beats.delete();
        set_cfg(16, 4'd8, 1'b0, 1'b0, 2'd0);
        mst.ready = 1'b0;
        send_frame(9'h042, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
        tick(16);
        n_cmp++;
        if (fifo_level !== 4'd1) begin n_bad++; $display("FAIL rstmid_prefill: got %0d want 1", fifo_level); end
        fork
            send_frame(9'h0F0, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
            begin
                tick(6 * 16);
                rst = 1'b1;
                tick(2);
                rst = 1'b0;
            end
        join
        tick(3 * 16);
        mst.ready = 1'b1;
        tick(16);
        n_cmp++;
        if (fifo_level !== '0 || beats.size() != 0 || mst.valid !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_discard: got level %0d beats %0d valid %b want 0 0 0",
                              fifo_level, beats.size(), mst.valid);
        end
    endtask

    initial begin
        rst            = 1'b1;
        rx             = 1'b1;
        err_clear      = 1'b0;
        parity_select  = 1'b0;
        parity_control = 1'b0;
        data_length    = 4'd8;
        stop_bits      = 2'd0;
        baud_rate      = DW'(16);
        mst.ready      = 1'b1;
        pause.req      = 1'b0;
        test_reset();
        test_baud434();
        test_back_to_back();
        test_formats();
        test_parity();
        test_frame_break();
        test_glitch();
        test_overrun();
        test_pause();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
